post_process_nch: RTL and testbench
===================================

POST_PROCESS_NCH -- requirements
Module: post_process_nch

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of parallel output-channel lanes.
REQ-002 SHALL have parameter DATA_WIDTH_I, default 22: signed accumulator width per lane.
REQ-003 SHALL have parameter DATA_WIDTH_O, default 8: signed quantised output width per lane.
REQ-004 SHALL have parameter BIAS_WIDTH, default 32: signed bias width.
REQ-005 SHALL have parameter BIAS_DEPTH, default 64: bias entries per lane; AW = clog2(BIAS_DEPTH).
REQ-006 SHALL have the port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have the port rst, input, 1: synchronous reset, active-low.
REQ-008 SHALL have the port start, input, 1: one-cycle pulse that latches config and begins a run.
REQ-009 SHALL have the ports cfg_width_out [7:0], cfg_height_out [9:0] and cfg_passes [1:0], all inputs: last column index, last row index and last pass index.
REQ-010 SHALL have the ports cfg_base_addr [AW-1:0], cfg_shift [3:0] and cfg_act [0:0], all inputs: first bias index, arithmetic right-shift and ReLU enable.
REQ-011 SHALL have the ports bias_we input 1, bias_waddr input AW and bias_wdata input NUM_CH*BIAS_WIDTH: bias write port, lane k in slice k.
REQ-012 SHALL have the ports in_valid input 1, in_ready output 1 and in_data input NUM_CH*DATA_WIDTH_I: accumulator beat stream.
REQ-013 SHALL have the ports out_valid output 1, out_ready input 1 and out_data output NUM_CH*DATA_WIDTH_O: quantised beat stream.
REQ-014 SHALL have the ports busy, output, 1 (high outside IDLE) and done, output, 1 (one-cycle pulse at end of run).

Function
REQ-015 SHALL implement FSM IDLE->RUN on start; RUN->IDLE in the cycle the final beat is accepted at the output, with done=1 in that cycle.
REQ-016 SHALL ignore start while not in IDLE.
REQ-017 SHALL latch all cfg_* inputs on start in IDLE and hold them constant for the run.
REQ-018 SHALL count accepted input beats with col 0..cfg_width_out, then row 0..cfg_height_out, then pass 0..cfg_passes; each counter wraps to 0 when it carries into the next.
REQ-019 SHALL deassert in_ready in IDLE and after the last beat (col, row and pass all at max) is accepted.
REQ-020 SHALL use bias index cfg_base_addr+pass for each beat, modulo BIAS_DEPTH.
REQ-021 SHALL compute each lane as: sum = sign-extended in + bias at BIAS_WIDTH+1 bits without overflow; q = sum >>> cfg_shift (arithmetic); if cfg_act and q<0 then q=0; then saturate q to [-2^(DATA_WIDTH_O-1), 2^(DATA_WIDTH_O-1)-1].
REQ-022 SHALL use a two-stage elastic pipeline (stage 1: bias add; stage 2: shift/act/saturate); each stage advances when it is empty or its data is being taken.
REQ-023 SHALL have a latency of 2 cycles from in_valid&&in_ready to out_valid when out_ready=1, with one beat per cycle sustained.
REQ-024 SHALL hold out_data stable while out_valid&&!out_ready, and SHALL NOT drop or duplicate beats under any out_ready pattern.
REQ-025 SHALL apply bias writes in the cycle after bias_we and ignore them while busy.
REQ-026 SHALL treat cfg_width_out=cfg_height_out=cfg_passes=0 as a single-beat run.

Reset
REQ-027 SHALL, when rst=0, clear the FSM to IDLE, clear all counters and pipeline valids, and drive out_valid=0, in_ready=0, busy=0, done=0 and out_data=0.
REQ-028 SHALL, on reset mid-run, discard in-flight beats, emit no done pulse and leave bias contents unchanged.

Configuration
REQ-029 SHALL, with POST_PROCESS_ROUND_EN defined, add 2^(cfg_shift-1) before the shift when cfg_shift>0 (round-half-up); without the macro it SHALL truncate toward minus infinity.

Structure
REQ-030 SHALL place the FSM state typedef and the saturation-limit constants in shared package post_process_pkg.
REQ-031 SHALL implement one lane datapath as sub-module pp_lane_quant, instantiated NUM_CH times, with the bias store, counters and handshake in the top module.

Verification
REQ-032 SHALL be checked with width 3, height 1, passes 0, out_ready=1: 8 beats out, done coincident with the 8th, latency 2.
REQ-033 SHALL be checked with in=1000, bias=24, shift=3, act=1: out=127 (saturated); with in=-1000 the out is 0.
REQ-034 SHALL be checked with act=0, in=-5, bias=0, shift=1: -3 without the macro and -2 with POST_PROCESS_ROUND_EN.
REQ-035 SHALL be checked with passes=2, base_addr=BIAS_DEPTH-1: pass biases are taken from indices 63, 0 and 1.
REQ-036 SHALL be checked with out_ready randomly 50% low: the output sequence equals the reference model, no loss, out_data held while stalled.
REQ-037 SHALL be checked with rst=0 after beat 5 and then a fresh start: the new run completes correctly with no stale beats.

Source files
------------

// File: rtl/post_process_pkg.sv
// Shared FSM state encoding and output saturation limits for post_process_nch.
package post_process_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Largest and smallest values representable in a signed w-bit output.
  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/pp_lane_quant.sv
// One lane of the post-process datapath: bias add, then shift/ReLU/saturate.
// POST_PROCESS_ROUND_EN selects round-half-up before the shift instead of flooring.
module pp_lane_quant
  import post_process_pkg::*;
#(
  parameter int DATA_WIDTH_I = 22,
  parameter int DATA_WIDTH_O = 8,
  parameter int BIAS_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_sum,
  input  logic                           load_out,
  input  logic signed [DATA_WIDTH_I-1:0] acc,
  input  logic signed [BIAS_WIDTH-1:0]   bias,
  input  logic [3:0]                     shift,
  input  logic                           act,
  output logic signed [DATA_WIDTH_O-1:0] result
);

  localparam int SW = BIAS_WIDTH + 1;
  localparam int RW = BIAS_WIDTH + 2;
  localparam logic signed [RW-1:0] HI = RW'(sat_hi(DATA_WIDTH_O));
  localparam logic signed [RW-1:0] LO = RW'(sat_lo(DATA_WIDTH_O));

  logic signed [SW-1:0]           sum;
  logic signed [RW-1:0]           pre;
  logic signed [RW-1:0]           q;
  logic signed [DATA_WIDTH_O-1:0] sat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum <= '0;
    end else if (load_sum) begin
      sum <= {{(SW-DATA_WIDTH_I){acc[DATA_WIDTH_I-1]}}, acc} + {bias[BIAS_WIDTH-1], bias};
    end
  end

  // One extra headroom bit keeps the rounding increment from overflowing.
  always_comb begin
    pre = {sum[SW-1], sum};
`ifdef POST_PROCESS_ROUND_EN
    if (shift != 4'd0) pre = pre + (RW'(1) << (shift - 4'd1));
`endif
    q = pre >>> shift;
    if (act && q[RW-1]) q = '0;
    if (q > HI)      sat = HI[DATA_WIDTH_O-1:0];
    else if (q < LO) sat = LO[DATA_WIDTH_O-1:0];
    else             sat = q[DATA_WIDTH_O-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      result <= '0;
    end else if (load_out) begin
      result <= sat;
    end
  end

endmodule

// File: rtl/post_process_nch.sv
// Multi-lane post-processing: per-pass bias add, shift, optional ReLU and saturation
// behind a two-stage elastic pipeline. Rounding mode is selected by POST_PROCESS_ROUND_EN.
module post_process_nch
  import post_process_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_WIDTH_I = 22,
  parameter int DATA_WIDTH_O = 8,
  parameter int BIAS_WIDTH   = 32,
  parameter int BIAS_DEPTH   = 64,
  localparam int AW          = $clog2(BIAS_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [7:0]                     cfg_width_out,
  input  logic [9:0]                     cfg_height_out,
  input  logic [1:0]                     cfg_passes,
  input  logic [AW-1:0]                  cfg_base_addr,
  input  logic [3:0]                     cfg_shift,
  input  logic [0:0]                     cfg_act,
  input  logic                           bias_we,
  input  logic [AW-1:0]                  bias_waddr,
  input  logic [NUM_CH*BIAS_WIDTH-1:0]   bias_wdata,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH*DATA_WIDTH_I-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH*DATA_WIDTH_O-1:0] out_data,
  output logic                           busy,
  output logic                           done
);

  state_t        state;
  logic [7:0]    width_q;
  logic [9:0]    height_q;
  logic [1:0]    passes_q;
  logic [AW-1:0] base_q;
  logic [3:0]    shift_q;
  logic          act_q;
  logic [7:0]    col;
  logic [9:0]    row;
  logic [1:0]    pass;
  logic          in_done;
  logic          s1_valid, s1_last, s2_valid, s2_last;
  logic          adv1, adv2, accept, last_beat;
  logic [AW:0]   idx_sum;
  logic [AW-1:0] bias_idx;
  logic [NUM_CH*BIAS_WIDTH-1:0] bias_mem [BIAS_DEPTH];
  logic [NUM_CH*BIAS_WIDTH-1:0] bias_row;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = (state == ST_RUN) && !in_done && adv1;
  assign accept    = in_valid && in_ready;
  assign last_beat = (col == width_q) && (row == height_q) && (pass == passes_q);
  assign out_valid = s2_valid;
  assign done      = (state == ST_RUN) && s2_valid && s2_last && out_ready;
  assign busy      = (state != ST_IDLE);

  // Bias index wraps modulo BIAS_DEPTH; one subtraction suffices since pass <= 3.
  assign idx_sum  = {1'b0, base_q} + (AW+1)'(pass);
  assign bias_idx = (idx_sum >= (AW+1)'(BIAS_DEPTH)) ? AW'(idx_sum - (AW+1)'(BIAS_DEPTH))
                                                     : AW'(idx_sum);
  assign bias_row = bias_mem[bias_idx];

  // The bias store has no reset so its contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (bias_we && state == ST_IDLE) bias_mem[bias_waddr] <= bias_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      width_q  <= '0;
      height_q <= '0;
      passes_q <= '0;
      base_q   <= '0;
      shift_q  <= '0;
      act_q    <= 1'b0;
      col      <= '0;
      row      <= '0;
      pass     <= '0;
      in_done  <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        if (start) begin
          width_q  <= cfg_width_out;
          height_q <= cfg_height_out;
          passes_q <= cfg_passes;
          base_q   <= cfg_base_addr;
          shift_q  <= cfg_shift;
          act_q    <= cfg_act[0];
          col      <= '0;
          row      <= '0;
          pass     <= '0;
          in_done  <= 1'b0;
          state    <= ST_RUN;
        end
      end else if (done) begin
        state <= ST_IDLE;
      end

      // Column is the fastest counter, then row, then pass.
      if (accept) begin
        if (col != width_q) begin
          col <= col + 8'd1;
        end else begin
          col <= '0;
          if (row != height_q) begin
            row <= row + 10'd1;
          end else begin
            row <= '0;
            if (pass != passes_q) begin
              pass <= pass + 2'd1;
            end else begin
              pass    <= '0;
              in_done <= 1'b1;
            end
          end
        end
      end

      if (adv1) begin
        s1_valid <= accept;
        s1_last  <= accept && last_beat;
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        s2_last  <= s1_last;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    pp_lane_quant #(
      .DATA_WIDTH_I(DATA_WIDTH_I),
      .DATA_WIDTH_O(DATA_WIDTH_O),
      .BIAS_WIDTH  (BIAS_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load_sum(accept),
      .load_out(adv2 && s1_valid),
      .acc     (in_data[k*DATA_WIDTH_I +: DATA_WIDTH_I]),
      .bias    (bias_row[k*BIAS_WIDTH +: BIAS_WIDTH]),
      .shift   (shift_q),
      .act     (act_q),
      .result  (out_data[k*DATA_WIDTH_O +: DATA_WIDTH_O])
    );
  end

endmodule

// File: tb/tb_post_process_nch.sv
// Self-checking bench for post_process_nch against an arithmetic reference model;
// honours POST_PROCESS_ROUND_EN in the same way as the design.
module tb_post_process_nch;

  localparam int NUM_CH = 4;
  localparam int DI     = 22;
  localparam int DO     = 8;
  localparam int BW     = 32;
  localparam int BD     = 64;
  localparam int AW     = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [7:0]           cfg_width_out;
  logic [9:0]           cfg_height_out;
  logic [1:0]           cfg_passes;
  logic [AW-1:0]        cfg_base_addr;
  logic [3:0]           cfg_shift;
  logic [0:0]           cfg_act;
  logic                 bias_we;
  logic [AW-1:0]        bias_waddr;
  logic [NUM_CH*BW-1:0] bias_wdata;
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_CH*DI-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_CH*DO-1:0] out_data;
  logic                 busy;
  logic                 done;

  int total_checks  = 0;
  int passed_checks = 0;
  longint bias_model [NUM_CH][BD];
  logic signed [DO-1:0] last_lane0;

  always #5 clk = ~clk;

  post_process_nch #(
    .NUM_CH(NUM_CH), .DATA_WIDTH_I(DI), .DATA_WIDTH_O(DO), .BIAS_WIDTH(BW), .BIAS_DEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width_out(cfg_width_out), .cfg_height_out(cfg_height_out), .cfg_passes(cfg_passes),
    .cfg_base_addr(cfg_base_addr), .cfg_shift(cfg_shift), .cfg_act(cfg_act),
    .bias_we(bias_we), .bias_waddr(bias_waddr), .bias_wdata(bias_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    assert (got === exp) passed_checks++;
    else $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Quantisation rule: add, shift (floor or round-half-up), optional ReLU, clamp.
  function automatic longint refModel(input longint acc, input longint b, input int sh, input bit act);
    longint v;
    v = acc + b;
`ifdef POST_PROCESS_ROUND_EN
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
    v = v >>> sh;
    if (act && v < 0) v = 0;
    if (v > (2**(DO-1)) - 1) v = (2**(DO-1)) - 1;
    if (v < -(2**(DO-1))) v = -(2**(DO-1));
    return v;
  endfunction

  task automatic writeBias(input int idx, input bit rand_en, input longint val);
    logic [NUM_CH*BW-1:0] word;
    for (int k = 0; k < NUM_CH; k++) begin
      longint v;
      v = rand_en ? (longint'($urandom_range(0, 8191)) - 4096) : val;
      bias_model[k][idx] = v;
      word[k*BW +: BW] = v[BW-1:0];
    end
    bias_we    = 1'b1;
    bias_waddr = AW'(idx);
    bias_wdata = word;
    @(negedge clk);
    bias_we = 1'b0;
  endtask

  task automatic applyStimulus(input int w, input int h, input int p, input int base, input int sh,
                               input bit act, input int rdy_pct, input int vld_pct,
                               input bit fixed_en, input longint fixed_val,
                               input int abort_after, input bit check_lat);
    logic [NUM_CH*DO-1:0] exp_q[$];
    int                   acc_q[$];
    logic [NUM_CH*DO-1:0] exp_word;
    logic [NUM_CH*DO-1:0] held;
    longint               cur_in [NUM_CH];
    int                   total, sent, recv, budget, pidx, bidx, acc_cyc;
    bit                   hold_pending, fired, out_fire;

    total        = (w + 1) * (h + 1) * (p + 1);
    sent         = 0;
    recv         = 0;
    hold_pending = 1'b0;
    fired        = 1'b0;
    held         = '0;
    budget       = total * 25 + 50;

    cfg_width_out  = 8'(w);
    cfg_height_out = 10'(h);
    cfg_passes     = 2'(p);
    cfg_base_addr  = AW'(base);
    cfg_shift      = 4'(sh);
    cfg_act        = act;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_width_out  = 8'($urandom);
    cfg_height_out = 10'($urandom);
    cfg_passes     = 2'($urandom);
    cfg_base_addr  = AW'($urandom);
    cfg_shift      = 4'($urandom);
    cfg_act        = 1'($urandom);
    checkOutput("busy_run", busy, 1);

    for (int cyc = 0; cyc < budget && recv < total; cyc++) begin
      if (abort_after > 0 && sent >= abort_after) break;
      if (fired || !in_valid) begin
        in_valid = 1'b0;
        if (sent < total && int'($urandom_range(0, 99)) < vld_pct) begin
          in_valid = 1'b1;
          for (int k = 0; k < NUM_CH; k++) begin
            longint v;
            if (fixed_en)                       v = fixed_val;
            else if ($urandom_range(0, 7) == 0) v = longint'($urandom_range(0, (1 << DI) - 1)) - (1 << (DI - 1));
            else                                v = longint'($urandom_range(0, 8191)) - 4096;
            cur_in[k] = v;
            in_data[k*DI +: DI] = v[DI-1:0];
          end
        end
      end
      out_ready = int'($urandom_range(0, 99)) < rdy_pct;
      #1;
      if (hold_pending) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_hold", out_data, held);
      end
      if (sent == total) checkOutput("in_ready_low", in_ready, 0);
      fired = in_valid && in_ready;
      if (fired) begin
        pidx = sent / ((w + 1) * (h + 1));
        bidx = (base + pidx) % BD;
        for (int k = 0; k < NUM_CH; k++) begin
          longint r;
          r = refModel(cur_in[k], bias_model[k][bidx], sh, act);
          exp_word[k*DO +: DO] = r[DO-1:0];
        end
        exp_q.push_back(exp_word);
        acc_q.push_back(cyc);
        sent++;
      end
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_beat", out_valid, 0);
        end else begin
          exp_word = exp_q.pop_front();
          acc_cyc  = acc_q.pop_front();
          checkOutput("out_data", out_data, exp_word);
          if (check_lat) checkOutput("latency", cyc - acc_cyc, 2);
          recv++;
          last_lane0 = out_data[DO-1:0];
        end
      end
      checkOutput("done", done, out_fire && recv == total);
      hold_pending = out_valid && !out_ready;
      held         = out_data;
      @(negedge clk);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (abort_after > 0) begin
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_in_ready", in_ready, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_out_data", out_data, 0);
      rst = 1'b1;
      @(negedge clk);
    end else begin
      checkOutput("beat_count", recv, total);
      checkOutput("busy_end", busy, 0);
      checkOutput("in_ready_idle", in_ready, 0);
    end
  endtask

  initial begin
    longint exp_neg;
`ifdef POST_PROCESS_ROUND_EN
    exp_neg = -2;
`else
    exp_neg = -3;
`endif
    rst            = 1'b0;
    start          = 1'b0;
    cfg_width_out  = '0;
    cfg_height_out = '0;
    cfg_passes     = '0;
    cfg_base_addr  = '0;
    cfg_shift      = '0;
    cfg_act        = '0;
    bias_we        = 1'b0;
    bias_waddr     = '0;
    bias_wdata     = '0;
    in_valid       = 1'b0;
    in_data        = '0;
    out_ready      = 1'b0;
    last_lane0     = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_out_data", out_data, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < BD; i++) writeBias(i, 1'b1, 0);

    $display("[TB] basic 4x2 run, full throughput");
    applyStimulus(3, 1, 0, 5, 4, 1'b0, 100, 100, 1'b0, 0, 0, 1'b1);

    $display("[TB] saturation and ReLU");
    writeBias(10, 1'b0, 24);
    applyStimulus(0, 0, 0, 10, 3, 1'b1, 100, 100, 1'b1, 1000, 0, 1'b1);
    checkOutput("sat_pos", longint'(last_lane0), 127);
    applyStimulus(0, 0, 0, 10, 3, 1'b1, 100, 100, 1'b1, -1000, 0, 1'b1);
    checkOutput("relu_zero", longint'(last_lane0), 0);

    $display("[TB] negative shift rounding");
    writeBias(11, 1'b0, 0);
    applyStimulus(0, 0, 0, 11, 1, 1'b0, 100, 100, 1'b1, -5, 0, 1'b1);
    checkOutput("neg_shift", longint'(last_lane0), exp_neg);

    $display("[TB] bias index wrap");
    writeBias(63, 1'b0, -300);
    writeBias(0, 1'b0, 500);
    writeBias(1, 1'b0, 200);
    applyStimulus(0, 0, 2, 63, 2, 1'b0, 100, 100, 1'b1, 0, 0, 1'b1);
    checkOutput("wrap_last", longint'(last_lane0), 50);

    $display("[TB] random backpressure");
    for (int r = 0; r < 3; r++)
      applyStimulus($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, BD - 1), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                    50, 70, 1'b0, 0, 0, 1'b0);

    $display("[TB] mid-run reset then fresh run");
    applyStimulus(3, 2, 0, 20, 5, 1'b0, 60, 80, 1'b0, 0, 5, 1'b0);
    applyStimulus(2, 1, 1, 62, 6, 1'b1, 50, 80, 1'b0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
